// File: rtl/alu_issue.sv
// Single-issue front end for an external combinational ALU: small register file,
// operand fetch, and a three-state IDLE/EXEC/WB sequencer.
module alu_issue #(
    parameter  int NREGS = 8,
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          InstValid,
    output logic          InstReady,
    input  logic [1:0]    InstOp,
    input  logic [AW-1:0] InstRd,
    input  logic [AW-1:0] InstRs1,
    input  logic [AW-1:0] InstRs2,
    input  logic          InstImmSel,
    input  logic [31:0]   InstImm,
    output logic [31:0]   AluA,
    output logic [31:0]   AluB,
    output logic [1:0]    AluOp,
    input  logic [31:0]   AluResult,
    output logic          WbValid,
    output logic [AW-1:0] WbRd,
    output logic [31:0]   WbData,
    input  logic [AW-1:0] DbgAddr,
    output logic [31:0]   DbgData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [31:0]   r_regs [NREGS];
    logic [31:0]   r_aluA;
    logic [31:0]   r_aluB;
    logic [1:0]    r_aluOp;
    logic [31:0]   r_wbData;
    logic [AW-1:0] r_pendRd;
    logic          w_accept;
    logic [31:0]   w_rs1Data;
    logic [31:0]   w_rs2Data;

    // Index 0 is hard-wired to zero on every read port.
    assign w_rs1Data = (InstRs1 == '0) ? 32'd0 : r_regs[InstRs1];
    assign w_rs2Data = (InstRs2 == '0) ? 32'd0 : r_regs[InstRs2];
    assign DbgData   = (DbgAddr == '0) ? 32'd0 : r_regs[DbgAddr];

    assign w_accept  = InstValid && InstReady;
    assign AluA      = r_aluA;
    assign AluB      = r_aluB;
    assign AluOp     = r_aluOp;
    assign WbData    = r_wbData;

    always_comb begin
        w_stateNext = r_state;
        InstReady   = 1'b0;
        WbValid     = 1'b0;
        WbRd        = '0;
        case (r_state)
            IDLE: begin
                InstReady = 1'b1;
                if (InstValid) begin
                    w_stateNext = EXEC;
                end
            end
            EXEC: begin
                w_stateNext = WB;
            end
            WB: begin
                WbValid     = 1'b1;
                WbRd        = r_pendRd;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Operands stay latched until the next accept so the ALU result is stable through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aluA   <= '0;
            r_aluB   <= '0;
            r_aluOp  <= '0;
            r_pendRd <= '0;
            r_wbData <= '0;
        end else begin
            if (w_accept) begin
                r_aluA   <= w_rs1Data;
                r_aluB   <= InstImmSel ? InstImm : w_rs2Data;
                r_aluOp  <= InstOp;
                r_pendRd <= InstRd;
            end
            if (r_state == EXEC) begin
                r_wbData <= AluResult;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if ((r_state == WB) && (r_pendRd != '0)) begin
            r_regs[r_pendRd] <= r_wbData;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized instructions
// checked against an architectural register-file model.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        InstValid;
    logic        InstReady;
    logic [1:0]  InstOp;
    logic [2:0]  InstRd;
    logic [2:0]  InstRs1;
    logic [2:0]  InstRs2;
    logic        InstImmSel;
    logic [31:0] InstImm;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [1:0]  AluOp;
    logic [31:0] AluResult;
    logic        WbValid;
    logic [2:0]  WbRd;
    logic [31:0] WbData;
    logic [2:0]  DbgAddr;
    logic [31:0] DbgData;

    int          vectorCount;
    int          missCount;
    logic [31:0] modelRegs [8];

    alu_issue #(.NREGS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InstValid  (InstValid),
        .InstReady  (InstReady),
        .InstOp     (InstOp),
        .InstRd     (InstRd),
        .InstRs1    (InstRs1),
        .InstRs2    (InstRs2),
        .InstImmSel (InstImmSel),
        .InstImm    (InstImm),
        .AluA       (AluA),
        .AluB       (AluB),
        .AluOp      (AluOp),
        .AluResult  (AluResult),
        .WbValid    (WbValid),
        .WbRd       (WbRd),
        .WbData     (WbData),
        .DbgAddr    (DbgAddr),
        .DbgData    (DbgData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] refAlu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return (b >= 32) ? 32'd0 : (a << b[4:0]);
            default: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
        endcase
    endfunction

    // The external ALU the block drives.
    assign AluResult = refAlu(AluOp, AluA, AluB);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [2:0] idx);
        return (idx == 3'd0) ? 32'd0 : modelRegs[idx];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 8; i++) modelRegs[i] = 32'd0;
    endtask

    // Issues one instruction and checks every stage of its three-cycle life.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic immSel, input logic [31:0] imm);
        logic [31:0] expA;
        logic [31:0] expB;
        logic [31:0] expRes;
        int          waitCnt;
        expA   = modelRead(rs1);
        expB   = immSel ? imm : modelRead(rs2);
        expRes = refAlu(op, expA, expB);
        waitCnt = 0;
        while (!InstReady && waitCnt < 10) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("readyBeforeIssue", {31'd0, InstReady}, 32'd1);
        InstValid  = 1'b1;
        InstOp     = op;
        InstRd     = rd;
        InstRs1    = rs1;
        InstRs2    = rs2;
        InstImmSel = immSel;
        InstImm    = imm;
        @(posedge clk);
        #1 InstValid = 1'b0;
        @(negedge clk);
        checkOutput("aluA", AluA, expA);
        checkOutput("aluB", AluB, expB);
        checkOutput("aluOp", {30'd0, AluOp}, {30'd0, op});
        checkOutput("execReady", {31'd0, InstReady}, 32'd0);
        checkOutput("execWbValid", {31'd0, WbValid}, 32'd0);
        @(negedge clk);
        checkOutput("wbValid", {31'd0, WbValid}, 32'd1);
        checkOutput("wbRd", {29'd0, WbRd}, {29'd0, rd});
        checkOutput("wbData", WbData, expRes);
        checkOutput("wbReady", {31'd0, InstReady}, 32'd0);
        if (rd != 3'd0) modelRegs[rd] = expRes;
        DbgAddr = rd;
        @(negedge clk);
        checkOutput("idleReady", {31'd0, InstReady}, 32'd1);
        checkOutput("idleWbValid", {31'd0, WbValid}, 32'd0);
        checkOutput("dbgAfterWb", DbgData, modelRead(rd));
    endtask

    task automatic checkAllRegs(input string tag);
        for (int i = 0; i < 8; i++) begin
            DbgAddr = 3'(i);
            #1 checkOutput(tag, DbgData, modelRead(3'(i)));
        end
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        clearModel();
        rst_n      = 1'b0;
        InstValid  = 1'b0;
        InstOp     = 2'b00;
        InstRd     = 3'd0;
        InstRs1    = 3'd0;
        InstRs2    = 3'd0;
        InstImmSel = 1'b0;
        InstImm    = 32'd0;
        DbgAddr    = 3'd0;
        repeat (2) @(negedge clk);
        checkOutput("rstReady", {31'd0, InstReady}, 32'd1);
        checkOutput("rstWbValid", {31'd0, WbValid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstReady", {31'd0, InstReady}, 32'd1);
        checkOutput("postRstWbValid", {31'd0, WbValid}, 32'd0);
        checkOutput("postRstAluA", AluA, 32'd0);
        checkOutput("postRstAluB", AluB, 32'd0);
        checkOutput("postRstWbData", WbData, 32'd0);
        checkAllRegs("postRstDbg");
        @(negedge clk);

        // Directed scenarios.
        applyStimulus(2'b00, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
        applyStimulus(2'b00, 3'd2, 3'd0, 3'd0, 1'b1, 32'd3);
        applyStimulus(2'b01, 3'd3, 3'd0, 3'd2, 1'b0, 32'd0);
        checkOutput("subResult", modelRegs[3], 32'hFFFF_FFFD);
        applyStimulus(2'b10, 3'd4, 3'd3, 3'd0, 1'b1, 32'd32);
        applyStimulus(2'b11, 3'd5, 3'd3, 3'd0, 1'b1, 32'd28);
        checkOutput("shrResult", modelRegs[5], 32'h0000_000F);
        applyStimulus(2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 32'd7);

        // Continuous InstValid: accepts only every third cycle, r1 doubles each time.
        applyStimulus(2'b00, 3'd1, 3'd0, 3'd0, 1'b1, 32'd1);
        InstValid  = 1'b1;
        InstOp     = 2'b00;
        InstRd     = 3'd1;
        InstRs1    = 3'd1;
        InstRs2    = 3'd1;
        InstImmSel = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checkOutput("streamReady", {31'd0, InstReady}, {31'd0, (k % 3) == 0});
            checkOutput("streamWbValid", {31'd0, WbValid}, {31'd0, (k % 3) == 2});
            if ((k % 3) == 2) begin
                modelRegs[1] = modelRegs[1] + modelRegs[1];
                checkOutput("streamWbData", WbData, modelRegs[1]);
            end
            if (k == 8) InstValid = 1'b0;
            @(negedge clk);
        end
        checkOutput("streamFinal", modelRegs[1], 32'd8);
        DbgAddr = 3'd1;
        #1 checkOutput("streamDbg", DbgData, 32'd8);

        // Randomized instructions against the register-file model.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] imm;
            logic [1:0]  op;
            op  = 2'($urandom_range(3, 0));
            imm = (op[1] && ($urandom_range(1, 0) == 1)) ? 32'($urandom_range(40, 0)) : $urandom;
            applyStimulus(op, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                          3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), imm);
        end
        checkAllRegs("randomDbg");

        // Reset during EXEC aborts the instruction entirely.
        InstValid  = 1'b1;
        InstOp     = 2'b00;
        InstRd     = 3'd6;
        InstRs1    = 3'd0;
        InstImmSel = 1'b1;
        InstImm    = 32'd9;
        @(posedge clk);
        #1 InstValid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abortRstWbValid", {31'd0, WbValid}, 32'd0);
        rst_n = 1'b1;
        clearModel();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("abortWbValid", {31'd0, WbValid}, 32'd0);
            checkOutput("abortReady", {31'd0, InstReady}, 32'd1);
        end
        checkAllRegs("abortDbg");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
